// File: rtl/fir_seq_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed 9-tap FIR sequencer.
// Build option FIR_SEQ_ZERO_SKIP_EN removes zero-coefficient taps from the ACC schedule.
package fir_seq_pkg;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam int unsigned NTAPS = 9;
    localparam int unsigned DW    = 16;

`ifdef FIR_SEQ_ZERO_SKIP_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    // Symmetric coefficient set; the centre tap is applied negated.
    function automatic logic [31:0] coef(input int unsigned k,
                                         input logic [31:0] h0, input logic [31:0] h1,
                                         input logic [31:0] h2, input logic [31:0] h3,
                                         input logic [31:0] h4);
        case (k)
            0, 8:    return h4;
            1, 7:    return h3;
            2, 6:    return h2;
            3, 5:    return h1;
            default: return -h0;
        endcase
    endfunction

    function automatic bit tap_used(input logic [31:0] c);
        return !SKIP_ZERO || (c != '0);
    endfunction

    // Two taps share the first adder cycle, so cycles = active taps - 1.
    function automatic int unsigned acc_cycles(input logic [31:0] h0, input logic [31:0] h1,
                                               input logic [31:0] h2, input logic [31:0] h3,
                                               input logic [31:0] h4);
        int unsigned n;
        n = 0;
        for (int unsigned k = 0; k < NTAPS; k++)
            if (tap_used(coef(k, h0, h1, h2, h3, h4))) n++;
        return n - 1;
    endfunction

    // Tap index occupying schedule slot pos (slots beyond the active count map to tap 0).
    function automatic int unsigned seq_tap(input int unsigned pos,
                                            input logic [31:0] h0, input logic [31:0] h1,
                                            input logic [31:0] h2, input logic [31:0] h3,
                                            input logic [31:0] h4);
        int unsigned n;
        n = 0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (tap_used(coef(k, h0, h1, h2, h3, h4))) begin
                if (n == pos) return k;
                n++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/fir_seq_delay_line.sv
// Sample delay line for the FIR sequencer: taps[0] is the newest sample, all taps in parallel.
module fir_seq_delay_line
    import fir_seq_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned NTAPS = 9
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      shift,
    input  logic [DW-1:0]             din,
    output logic [NTAPS-1:0][DW-1:0]  taps
);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            taps <= '0;
        end else if (shift) begin
            taps[0] <= din;
            for (int unsigned k = 1; k < NTAPS; k++)
                taps[k] <= taps[k-1];
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// 9-tap symmetric FIR that sequences all tap products through one external adder.
// Build option FIR_SEQ_ZERO_SKIP_EN drops zero-coefficient taps from the schedule.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned   DW = 16,
    parameter logic [DW-1:0] H0 = 16'd32,
    parameter logic [DW-1:0] H1 = 16'd18,
    parameter logic [DW-1:0] H2 = 16'd6,
    parameter logic [DW-1:0] H3 = 16'd0,
    parameter logic [DW-1:0] H4 = 16'd2
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    input  logic [DW-1:0] add_o,
    output logic          busy
);

    localparam logic [31:0] P0 = 32'(H0);
    localparam logic [31:0] P1 = 32'(H1);
    localparam logic [31:0] P2 = 32'(H2);
    localparam logic [31:0] P3 = 32'(H3);
    localparam logic [31:0] P4 = 32'(H4);
    localparam int unsigned NACC = acc_cycles(P0, P1, P2, P3, P4);

    state_t                   state;
    logic [3:0]               cnt;
    logic [DW-1:0]            acc;
    logic [NTAPS-1:0][DW-1:0] taps;
    logic [DW-1:0]            seq_mul [NTAPS];
    logic                     shift;

    assign in_ready = rstN && (state == IDLE);
    assign shift    = in_valid && in_ready;

    fir_seq_delay_line #(
        .DW    (DW),
        .NTAPS (NTAPS)
    ) u_dl (
        .clk   (clk),
        .rstN  (rstN),
        .shift (shift),
        .din   (x),
        .taps  (taps)
    );

    // Products laid out in schedule order; low DW bits are sign-agnostic.
    for (genvar n = 0; n < NTAPS; n++) begin : g_seq
        localparam int unsigned   T = seq_tap(n, P0, P1, P2, P3, P4);
        localparam logic [DW-1:0] C = DW'(coef(T, P0, P1, P2, P3, P4));
        assign seq_mul[n] = taps[T] * C;
    end

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == ACC) begin
            add_a = (cnt == 4'd1) ? seq_mul[0] : seq_mul[cnt];
            add_b = (cnt == 4'd1) ? seq_mul[1] : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shift) begin
                        cnt   <= 4'd1;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= add_o;
                    if (cnt == 4'(NACC)) begin
                        y         <= add_o;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with an exact adder stub on the shared adder port.
module tb_fir_mac_sequencer;

    localparam int unsigned DW = 16;
`ifdef FIR_SEQ_ZERO_SKIP_EN
    localparam int EXP_LAT = 7;
`else
    localparam int EXP_LAT = 9;
`endif

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] x = '0;
    logic          in_ready, out_valid, busy;
    logic [DW-1:0] y, add_a, add_b, add_o;

    int unsigned total  = 0;
    int unsigned passed = 0;

    int imp_y  [10] = '{2, 0, 6, 18, -32, 18, 6, 0, 2, 0};
    int ovf_y  [10] = '{4000, 0, 12000, -29536, 1536, -29536, 12000, 0, 4000, 0};
    int step_y [12] = '{200, 200, 800, 2600, -600, 1200, 1800, 1800, 2000, 2000, 2000, 2000};

    always #5 clk = ~clk;

    assign add_o = add_a + add_b;

    fir_mac_sequencer #(
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_o     (add_o),
        .busy      (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Offer one sample, wait for the result, optionally stall the output for `hold` cycles.
    task automatic send(input logic [DW-1:0] s, input int exp_y, input string tag,
                        input int unsigned hold);
        int unsigned w;
        int unsigned lat;
        x = s;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({tag, " in_ready"}, int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = '0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, int'(lat), EXP_LAT);
        check({tag, " y"}, int'($signed(y)), exp_y);
        if (hold > 0) begin
            in_valid = 1'b1;
            x = 16'd555;
            for (int unsigned c = 0; c < hold; c++) begin
                @(negedge clk);
                check($sformatf("%s hold%0d out_valid", tag, c), int'(out_valid), 1);
                check($sformatf("%s hold%0d y", tag, c), int'($signed(y)), exp_y);
                check($sformatf("%s hold%0d in_ready", tag, c), int'(in_ready), 0);
                check($sformatf("%s hold%0d add_a", tag, c), int'(add_a), 0);
            end
            in_valid = 1'b0;
            x = '0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset state
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst y", int'(y), 0);
        check("rst busy", int'(busy), 0);
        check("rst add_a", int'(add_a), 0);
        check("rst add_b", int'(add_b), 0);
        rstN = 1'b1;
        @(negedge clk);
        check("idle in_ready", int'(in_ready), 1);

        // Impulse
        for (int i = 0; i < 10; i++)
            send((i == 0) ? 16'd1 : 16'd0, imp_y[i], $sformatf("imp%0d", i), 0);

        // Overflow wrap
        for (int i = 0; i < 10; i++)
            send((i == 0) ? 16'd2000 : 16'd0, ovf_y[i], $sformatf("ovf%0d", i), 0);

        // Step
        for (int i = 0; i < 12; i++)
            send(16'd100, step_y[i], $sformatf("step%0d", i), 0);

        // Backpressure: stalled output, ignored input offers
        send(16'd0, 1800, "bp", 5);
        check("bp release out_valid", int'(out_valid), 0);
        check("bp release in_ready", int'(in_ready), 1);
        send(16'd0, 1800, "bp_next1", 0);
        send(16'd0, 1200, "bp_next2", 0);

        // Reset pulse in the middle of accumulation
        x = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midacc busy", int'(busy), 1);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst in_ready", int'(in_ready), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst add_a", int'(add_a), 0);
        rstN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            @(negedge clk);
        end
        check("abandoned no out_valid", int'(seen), 0);
        send(16'd1, 2, "post_rst0", 0);
        send(16'd0, 0, "post_rst1", 0);
        send(16'd0, 6, "post_rst2", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
